// File: rtl/mem_responder_pkg.sv
// Shared constants for mem_responder: region decode, IO addresses, status bits.
package mem_responder_pkg;

  // Values of addr[17:16] that select the non-RAM regions (addr[17]=0 is RAM).
  localparam logic [1:0] RegionSelRsvd = 2'b10;
  localparam logic [1:0] RegionSelIo   = 2'b11;

  localparam logic [17:0] IoTxAddr     = 18'h30000;
  localparam logic [17:0] IoStatusAddr = 18'h30004;

  // Status register bit positions; writing 1 to StatOvfBit clears ovf.
  localparam int unsigned StatEmptyBit = 0;
  localparam int unsigned StatFullBit  = 1;
  localparam int unsigned StatOvfBit   = 2;

  typedef enum logic [1:0] {
    RegionRam,
    RegionRsvd,
    RegionIo
  } region_e;

  function automatic region_e decode_region(logic [17:0] addr);
    if (!addr[17]) begin
      return RegionRam;
    end else if (addr[17:16] == RegionSelIo) begin
      return RegionIo;
    end else begin
      return RegionRsvd;
    end
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory port plus TX stream of mem_responder.
interface mem_responder_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_full;

  modport slave (
    input  rdy_in, mem_a, mem_wr, mem_dout, tx_ready,
    output mem_din, tx_data, tx_valid, tx_full
  );

  modport master (
    output rdy_in, mem_a, mem_wr, mem_dout, tx_ready,
    input  mem_din, tx_data, tx_valid, tx_full
  );
endinterface

// File: rtl/mem_responder_tx_fifo.sv
// tx_fifo: first-word-fall-through byte FIFO with a full-but-popping push path.
module tx_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push_req,
  input  logic [7:0] push_data,
  input  logic       pop_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_full,
  output logic       drop
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               pop, push;

  assign tx_valid = (count_q != '0);
  assign tx_full  = (count_q == DepthCnt);
  // Head byte forced to zero when empty so reset/empty both present 0x00.
  assign tx_data  = tx_valid ? mem_q[rptr_q] : 8'h00;

  assign pop  = tx_valid & pop_ready;
  // A full FIFO can still accept a byte when the head leaves the same cycle.
  assign push = push_req & (~tx_full | pop);
  assign drop = push_req & tx_full & ~pop;

  // Pointer/count next state; pointers wrap naturally at FIFO_AW bits.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Pointer state; reset empties the FIFO immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless once pointers reset.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM, reserved region and optional IO TX FIFO behind a CPU port.
// Optional feature macro: MEM_RESPONDER_IO_EN (IO region + TX FIFO). Undefined: IO reads as
// reserved and TX outputs are tied low.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_AW  = 17,
  parameter int unsigned FIFO_AW = 3
) (
  input logic             clk_in,
  input logic             rst_in,
  mem_responder_if.slave  bus
);

  logic [17:0]       addr;
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;
  logic              ram_we;
  logic [7:0]        rd_data;
  logic [7:0]        io_rd_data;
  logic [7:0]        mem_din_q;
  logic              unused_addr_hi;

  logic [7:0] ram_q [2 ** RAM_AW];

  assign addr           = bus.mem_a[17:0];
  assign unused_addr_hi = ^bus.mem_a[31:18];
  assign ram_idx        = bus.mem_a[RAM_AW-1:0];
  assign region         = decode_region(addr);
  assign ram_we         = bus.rdy_in & bus.mem_wr & (region == RegionRam);
  assign bus.mem_din    = mem_din_q;

`ifdef MEM_RESPONDER_IO_EN
  logic io_wr, push_req, clr_ovf, drop;
  logic ovf_q;

  assign io_wr    = bus.rdy_in & bus.mem_wr & (region == RegionIo);
  assign push_req = io_wr & (addr == IoTxAddr);
  assign clr_ovf  = io_wr & (addr == IoStatusAddr) & bus.mem_dout[StatOvfBit];

  tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_req  (push_req),
    .push_data (bus.mem_dout),
    .pop_ready (bus.tx_ready),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_full   (bus.tx_full),
    .drop      (drop)
  );

  // Sticky overflow: set by a dropped push, cleared only by a status write.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ovf_q <= 1'b0;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  // Status register is the only readable IO location.
  always_comb begin
    io_rd_data = 8'h00;
    if (addr == IoStatusAddr) begin
      io_rd_data[StatOvfBit]   = ovf_q;
      io_rd_data[StatFullBit]  = bus.tx_full;
      io_rd_data[StatEmptyBit] = ~bus.tx_valid;
    end
  end
`else
  logic unused_tx_ready;

  assign unused_tx_ready = bus.tx_ready;
  assign io_rd_data      = 8'h00;
  assign bus.tx_data     = 8'h00;
  assign bus.tx_valid    = 1'b0;
  assign bus.tx_full     = 1'b0;
`endif

  // RAM write port; RAM is deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_idx] <= bus.mem_dout;
  end

  // Read mux across regions; reserved reads return zero.
  always_comb begin
    rd_data = 8'h00;
    case (region)
      RegionRam: rd_data = ram_q[ram_idx];
      RegionIo:  rd_data = io_rd_data;
      default:   rd_data = 8'h00;
    endcase
  end

  // Registered read data; held on writes and while the CPU port is stalled.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= 8'h00;
    end else if (bus.rdy_in && !bus.mem_wr) begin
      mem_din_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (adapts to MEM_RESPONDER_IO_EN).
module tb_mem_responder;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if bus ();

  mem_responder dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are applied at a falling edge; the next falling edge shows the result.
  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_wr   = 1'b1;
    bus.mem_a    = a;
    bus.mem_dout = d;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_wr   = 1'b0;
    bus.mem_a    = a;
    bus.mem_dout = 8'h00;
  endtask

  initial begin
    bus.rdy_in   = 1'b1;
    bus.tx_ready = 1'b0;
    rd(32'h0);
    tick();
    tick();
    check("reset_mem_din", bus.mem_din, 8'h00);
    check("reset_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("reset_tx_full", {7'b0, bus.tx_full}, 8'h00);
    check("reset_tx_data", bus.tx_data, 8'h00);
    rst_in = 1'b1;
    tick();

    // RAM write then read-back with one-cycle latency.
    wr(32'h00010, 8'hA5); tick();
    rd(32'h00010);        tick();
    check("ram_rd_a5", bus.mem_din, 8'hA5);

    // Reserved region reads zero; writes there are ignored and hold mem_din.
    wr(32'h00040, 8'h5A); tick();
    rd(32'h00040);        tick();
    check("ram_rd_5a", bus.mem_din, 8'h5A);
    rd(32'h2ABCD);        tick();
    check("rsvd_rd", bus.mem_din, 8'h00);
    wr(32'h20000, 8'hFF); tick();
    check("rsvd_wr_hold", bus.mem_din, 8'h00);
    rd(32'h00010);        tick();
    check("ram_rd_after_rsvd", bus.mem_din, 8'hA5);
    wr(32'h00010, 8'h11); tick();
    check("wr_holds_din", bus.mem_din, 8'hA5);
    rd(32'h00010);        tick();
    check("ram_rd_11", bus.mem_din, 8'h11);
    // High address bits are not decoded.
    rd(32'hFFFC0010);     tick();
    check("addr_alias", bus.mem_din, 8'h11);

`ifdef MEM_RESPONDER_IO_EN
    rd(32'h30004); tick();
    check("status_empty", bus.mem_din, 8'h01);

    // Fill to full with no draining, then overflow.
    for (int i = 1; i <= 8; i++) begin
      wr(32'h30000, 8'(i)); tick();
    end
    check("full_flag", {7'b0, bus.tx_full}, 8'h01);
    check("full_head", bus.tx_data, 8'h01);
    wr(32'h30000, 8'h09); tick();
    rd(32'h30004);        tick();
    check("status_ovf_full", bus.mem_din, 8'h06);
    check("ovf_head", bus.tx_data, 8'h01);

    // Non-clearing status write leaves ovf; a bit-2 write clears it.
    wr(32'h30004, 8'h03); tick();
    rd(32'h30004);        tick();
    check("ovf_kept", bus.mem_din, 8'h06);
    wr(32'h30004, 8'h04); tick();
    rd(32'h30004);        tick();
    check("ovf_cleared", bus.mem_din, 8'h02);

    // Push into a full FIFO while the head drains.
    bus.tx_ready = 1'b1;
    wr(32'h30000, 8'h55); tick();
    bus.tx_ready = 1'b0;
    check("push_pop_full", {7'b0, bus.tx_full}, 8'h01);
    check("push_pop_head", bus.tx_data, 8'h02);
    rd(32'h30004); tick();
    check("push_pop_status", bus.mem_din, 8'h02);

    rd(32'h00000);
    bus.tx_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      check("drain_valid", {7'b0, bus.tx_valid}, 8'h01);
      check("drain_data", bus.tx_data, (i == 9) ? 8'h55 : 8'(i));
      tick();
    end
    check("drained_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("drained_data", bus.tx_data, 8'h00);
    bus.tx_ready = 1'b0;

    // Stalled CPU port: RAM and mem_din frozen while the FIFO drains.
    wr(32'h00020, 8'h77); tick();
    rd(32'h00020);        tick();
    check("ram_rd_77", bus.mem_din, 8'h77);
    wr(32'h30000, 8'hC1); tick();
    wr(32'h30000, 8'hC2); tick();
    wr(32'h30000, 8'hC3); tick();
    bus.rdy_in   = 1'b0;
    bus.tx_ready = 1'b1;
    wr(32'h00020, 8'h99);
    for (int i = 1; i <= 3; i++) begin
      check("stall_drain", bus.tx_data, 8'hC0 + 8'(i));
      check("stall_hold", bus.mem_din, 8'h77);
      tick();
    end
    check("stall_empty", {7'b0, bus.tx_valid}, 8'h00);
    bus.rdy_in   = 1'b1;
    bus.tx_ready = 1'b0;
    rd(32'h00020); tick();
    check("stall_ram_kept", bus.mem_din, 8'h77);

    // Asynchronous reset with bytes queued.
    wr(32'h30000, 8'hD1); tick();
    wr(32'h30000, 8'hD2); tick();
    wr(32'h30000, 8'hD3); tick();
    check("queued_valid", {7'b0, bus.tx_valid}, 8'h01);
    rd(32'h00010);
    #2 rst_in = 1'b0;
    #1;
    check("async_rst_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("async_rst_data", bus.tx_data, 8'h00);
    check("async_rst_din", bus.mem_din, 8'h00);
    tick();
    rst_in = 1'b1;
    rd(32'h30004); tick();
    check("post_rst_status", bus.mem_din, 8'h01);
    rd(32'h00010); tick();
    check("ram_survives_rst", bus.mem_din, 8'h11);
`else
    // IO region behaves as reserved; TX side tied off.
    wr(32'h30000, 8'h42); tick();
    check("noio_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("noio_tx_data", bus.tx_data, 8'h00);
    check("noio_tx_full", {7'b0, bus.tx_full}, 8'h00);
    rd(32'h30004); tick();
    check("noio_status", bus.mem_din, 8'h00);
    rd(32'h00010); tick();
    check("noio_ram", bus.mem_din, 8'h11);
    rd(32'h30000); tick();
    check("noio_rd_tx", bus.mem_din, 8'h00);
    rd(32'h00010);
    #2 rst_in = 1'b0;
    #1;
    check("noio_async_rst_din", bus.mem_din, 8'h00);
    tick();
    rst_in = 1'b1;
    tick();
    check("noio_ram_survives_rst", bus.mem_din, 8'h11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
